// File: rtl/exec_arbiter_if.sv
// Bundle between the two requesters, the arbiter and the Execution stage.
// master = requester/Execution side, slave = arbiter.
interface exec_arbiter_if #(
  parameter int OP_W   = 6,
  parameter int DATA_W = 10,
  parameter int RES_W  = 8
);
  // Handshake: a requester raises req with op/data/lock held stable; the
  // request is consumed in the cycle its gnt is high (gnt is combinational).
  // The result returns one cycle later, qualified by that requester's valid.
  logic              stall;
  logic              req0;
  logic              req1;
  logic [OP_W-1:0]   op0;
  logic [OP_W-1:0]   op1;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic              lock0;
  logic              lock1;
  logic              gnt0;
  logic              gnt1;
  logic [OP_W-1:0]   operation_id;
  logic [DATA_W-1:0] data_id;
  logic [RES_W-1:0]  exec_result;
  logic              exec_carry;
  logic              valid0;
  logic              valid1;
  logic [RES_W-1:0]  result;
  logic              carry;
  // {last, lock_own, lock_id, in_flight, tag}
  logic [4:0]        state_dbg;

  modport master (
    output stall, req0, req1, op0, op1, data0, data1, lock0, lock1,
           exec_result, exec_carry,
    input  gnt0, gnt1, operation_id, data_id, valid0, valid1, result, carry,
           state_dbg
  );

  modport slave (
    input  stall, req0, req1, op0, op1, data0, data1, lock0, lock1,
           exec_result, exec_carry,
    output gnt0, gnt1, operation_id, data_id, valid0, valid1, result, carry,
           state_dbg
  );
endinterface

// File: rtl/exec_arbiter.sv
// Two-way round-robin arbiter with optional lock, feeding the single
// Execution stage and routing its result back to the owning requester.
module exec_arbiter #(
  parameter int             OP_W   = 6,
  parameter int             DATA_W = 10,
  parameter int             RES_W  = 8,
  parameter logic [OP_W-1:0] NOP_OP = '0
) (
  input logic            clk,
  input logic            rst,
  exec_arbiter_if.slave  bus
);

  logic last_q;
  logic lock_own_q;
  logic lock_id_q;
  logic in_flight_q;
  logic tag_q;

  logic gnt_any;
  logic gnt_id;
  logic lock_sel;
  logic owner_req;

  assign owner_req = lock_id_q ? bus.req1 : bus.req0;

  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = 1'b0;
    if (!(rst || bus.stall)) begin
      // A live lock wins only while its owner still requests; once the
      // owner drops req the other side may be granted in the same cycle.
      if (lock_own_q && owner_req) begin
        gnt_any = 1'b1;
        gnt_id  = lock_id_q;
      end else if (bus.req0 && bus.req1) begin
        gnt_any = 1'b1;
        gnt_id  = ~last_q;
      end else if (bus.req0) begin
        gnt_any = 1'b1;
        gnt_id  = 1'b0;
      end else if (bus.req1) begin
        gnt_any = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  assign lock_sel     = gnt_id ? bus.lock1 : bus.lock0;
  assign bus.gnt0     = gnt_any && !gnt_id;
  assign bus.gnt1     = gnt_any && gnt_id;
  assign bus.operation_id = !gnt_any ? NOP_OP  : (gnt_id ? bus.op1 : bus.op0);
  assign bus.data_id      = !gnt_any ? '0      : (gnt_id ? bus.data1 : bus.data0);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q      <= 1'b1;
      lock_own_q  <= 1'b0;
      lock_id_q   <= 1'b0;
      in_flight_q <= 1'b0;
      tag_q       <= 1'b0;
    end else begin
      in_flight_q <= gnt_any;
      tag_q       <= gnt_id;
      if (gnt_any) last_q <= gnt_id;
      // Stall freezes lock ownership so the owner resumes afterwards.
      if (!bus.stall) begin
        lock_own_q <= gnt_any && lock_sel;
        lock_id_q  <= gnt_id;
      end
    end
  end

  // Reset gates the return strobes so an op in flight at reset is dropped.
  assign bus.valid0    = in_flight_q && !rst && !tag_q;
  assign bus.valid1    = in_flight_q && !rst && tag_q;
  assign bus.result    = bus.exec_result;
  assign bus.carry     = bus.exec_carry;
  assign bus.state_dbg = {last_q, lock_own_q, lock_id_q, in_flight_q, tag_q};

endmodule

// File: tb/tb_exec_arbiter.sv
// Directed bench for exec_arbiter: grant order, lock, stall, idle NOP,
// reset during flight; expected values are hand-computed constants.
module tb_exec_arbiter;
  localparam int OP_W = 6, DATA_W = 10, RES_W = 8;
  localparam logic [OP_W-1:0] ADDA = 6'd1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  exec_arbiter_if #(.OP_W(OP_W), .DATA_W(DATA_W), .RES_W(RES_W)) bus ();

  exec_arbiter #(.OP_W(OP_W), .DATA_W(DATA_W), .RES_W(RES_W), .NOP_OP(6'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic r0, input logic r1, input logic l0, input logic l1);
    bus.req0  = r0;
    bus.req1  = r1;
    bus.lock0 = l0;
    bus.lock1 = l1;
  endtask

  // settle, then check grants and the issued op/data
  task automatic chk_issue(input string tag, input logic g0, input logic g1);
    #1;
    chk({tag, "_gnt0"}, {31'd0, bus.gnt0}, {31'd0, g0});
    chk({tag, "_gnt1"}, {31'd0, bus.gnt1}, {31'd0, g1});
    if (g0) begin
      chk({tag, "_op"},   {26'd0, bus.operation_id}, {26'd0, bus.op0});
      chk({tag, "_data"}, {22'd0, bus.data_id},      {22'd0, bus.data0});
    end else if (g1) begin
      chk({tag, "_op"},   {26'd0, bus.operation_id}, {26'd0, bus.op1});
      chk({tag, "_data"}, {22'd0, bus.data_id},      {22'd0, bus.data1});
    end else begin
      chk({tag, "_op"},   {26'd0, bus.operation_id}, 32'd0);
      chk({tag, "_data"}, {22'd0, bus.data_id},      32'd0);
    end
  endtask

  task automatic chk_valid(input string tag, input logic v0, input logic v1);
    chk({tag, "_valid0"}, {31'd0, bus.valid0}, {31'd0, v0});
    chk({tag, "_valid1"}, {31'd0, bus.valid1}, {31'd0, v1});
  endtask

  initial begin
    bus.stall = 1'b0;
    set_req(1'b1, 1'b0, 1'b0, 1'b0);
    bus.op0 = 6'd5;  bus.data0 = 10'd9;
    bus.op1 = 6'd4;  bus.data1 = 10'd7;
    bus.exec_result = 8'h00;
    bus.exec_carry  = 1'b0;

    // reset: requests ignored, NOP issued, reset state visible
    tick(); tick();
    chk_issue("rst", 1'b0, 1'b0);
    chk_valid("rst", 1'b0, 1'b0);
    chk("rst_state", {27'd0, bus.state_dbg}, 32'h10);

    // single request from 0, result one cycle later
    rst = 1'b0;
    bus.op0 = ADDA; bus.data0 = 10'd0;
    chk_issue("t1", 1'b1, 1'b0);
    chk("t1_op_adda", {26'd0, bus.operation_id}, {26'd0, ADDA});
    tick();
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    bus.exec_result = 8'h10; bus.exec_carry = 1'b0;
    chk_issue("t1_n1", 1'b0, 1'b0);
    chk_valid("t1_n1", 1'b1, 1'b0);
    chk("t1_result", {24'd0, bus.result}, 32'h10);
    chk("t1_carry", {31'd0, bus.carry}, 32'd0);

    // both requesting, last=0 so order is 1,0,1,0,1,0
    tick();
    bus.op0 = 6'd2; bus.data0 = 10'd3;
    set_req(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      bus.exec_result = 8'(i + 8'h20); bus.exec_carry = i[0];
      chk_issue($sformatf("rr%0d", i), (i % 2) == 1, (i % 2) == 0);
      if (i == 0) chk_valid("rr0", 1'b0, 1'b0);
      else        chk_valid($sformatf("rr%0d", i), (i % 2) == 0, (i % 2) == 1);
      chk($sformatf("rr%0d_result", i), {24'd0, bus.result}, 32'(i + 8'h20));
      chk($sformatf("rr%0d_carry", i), {31'd0, bus.carry}, {31'd0, i[0]});
      tick();
    end
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk_valid("rr_tail", 1'b1, 1'b0);

    // lock: first move last to 1, then lock0 for three grants
    tick();
    set_req(1'b0, 1'b1, 1'b0, 1'b0);
    chk_issue("lk_pre", 1'b0, 1'b1);
    tick();
    set_req(1'b1, 1'b1, 1'b1, 1'b0);
    chk_issue("lk_a", 1'b1, 1'b0);
    tick();
    chk_issue("lk_b", 1'b1, 1'b0);
    tick();
    chk_issue("lk_c", 1'b1, 1'b0);
    tick();
    set_req(1'b1, 1'b1, 1'b0, 1'b0);
    chk_issue("lk_d", 1'b1, 1'b0);
    tick();
    chk_issue("lk_e", 1'b0, 1'b1);
    chk_valid("lk_e", 1'b1, 1'b0);
    tick();
    chk_issue("lk_f", 1'b1, 1'b0);
    chk_valid("lk_f", 1'b0, 1'b1);
    tick();
    chk_issue("lk_g", 1'b0, 1'b1);

    // stall two cycles mid-stream (last=1)
    tick();
    chk_issue("st_a", 1'b1, 1'b0);
    tick();
    bus.stall = 1'b1;
    chk_issue("st_b", 1'b0, 1'b0);
    chk_valid("st_b", 1'b1, 1'b0);
    tick();
    chk_issue("st_c", 1'b0, 1'b0);
    chk_valid("st_c", 1'b0, 1'b0);
    tick();
    bus.stall = 1'b0;
    chk_issue("st_d", 1'b0, 1'b1);
    chk_valid("st_d", 1'b0, 1'b0);
    tick();
    chk_issue("st_e", 1'b1, 1'b0);
    chk_valid("st_e", 1'b0, 1'b1);

    // idle: NOP issued, nothing returns, Execution default result 0
    tick();
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    chk_issue("idle_a", 1'b0, 1'b0);
    chk_valid("idle_a", 1'b1, 1'b0);
    tick();
    bus.exec_result = 8'h00; bus.exec_carry = 1'b0;
    chk_issue("idle_b", 1'b0, 1'b0);
    chk_valid("idle_b", 1'b0, 1'b0);
    chk("idle_result", {24'd0, bus.result}, 32'd0);

    // reset in the cycle after a grant to 1 drops its valid
    tick();
    set_req(1'b0, 1'b1, 1'b0, 1'b0);
    chk_issue("rf_a", 1'b0, 1'b1);
    tick();
    rst = 1'b1;
    set_req(1'b1, 1'b0, 1'b0, 1'b0);
    chk_issue("rf_b", 1'b0, 1'b0);
    chk_valid("rf_b", 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    set_req(1'b1, 1'b1, 1'b0, 1'b0);
    chk_issue("rf_c", 1'b1, 1'b0);
    chk_valid("rf_c", 1'b0, 1'b0);

    // lock owner drops req: other side granted the same cycle
    tick();
    set_req(1'b1, 1'b0, 1'b1, 1'b0);
    chk_issue("ld_a", 1'b1, 1'b0);
    tick();
    set_req(1'b0, 1'b1, 1'b1, 1'b0);
    chk_issue("ld_b", 1'b0, 1'b1);

    // lock held across a stall cycle
    tick();
    set_req(1'b1, 1'b0, 1'b1, 1'b0);
    chk_issue("ls_a", 1'b1, 1'b0);
    tick();
    bus.stall = 1'b1;
    set_req(1'b1, 1'b1, 1'b0, 1'b0);
    chk_issue("ls_b", 1'b0, 1'b0);
    chk("ls_state", {27'd0, bus.state_dbg}, 32'h0A);
    tick();
    bus.stall = 1'b0;
    chk_issue("ls_c", 1'b1, 1'b0);
    tick();
    chk_issue("ls_d", 1'b0, 1'b1);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
